entry_alloc_64: RTL and testbench
=================================

Name: entry_alloc_64

Overview:
- 64-entry allocator/scheduler for any 6-bit-indexed resource: physical registers, TLB entries, or MSHR slots.
- Keeps a busy bitmap, hands out free 6-bit indices over a valid/ready handshake and accepts index releases.
- Allocation search is rotating-priority, so recently freed entries are not reused immediately.
- Set and clear masks come from one-hot 6-to-64 decodes of the grant and free indices.

Parameters:
- RR_EN, 1, 1 = search starts at last granted index + 1 (round-robin); 0 = fixed priority, lowest free index wins.
- CNT_W, 7, width of free_cnt; must be at least 7 so that 64 is representable.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous reset, active low
- flush  input  1  release all entries
- alloc_ready  input  1  requester accepts the offered index this cycle
- alloc_valid  output  1  a free entry is offered
- alloc_idx  output  6  offered index, valid when alloc_valid = 1
- free_valid  input  1  release request
- free_idx  input  6  index to release
- busy_vec  output  64  registered busy bitmap
- free_cnt  output  CNT_W  number of free entries, 0..64
- full  output  1  free_cnt == 0
- empty  output  1  free_cnt == 64
- err_dbl_free  output  1  sticky flag: a free targeted an entry that was not busy

Behaviour:
- Reset values (resetn = 0 at a clock edge): busy_vec = 0, free_cnt = 64, rr_ptr = 0, err_dbl_free = 0.
  - Derived outputs follow: alloc_valid = 1, alloc_idx = 0, full = 0, empty = 1.
  - Reset has priority over all other inputs. Reset mid-handshake drops the grant with no side effects.
- Offer path:
  - alloc_valid = ~full and ~flush.
  - alloc_idx is combinational from registered state only: the first 0 bit in busy_vec, searching upward from rr_ptr with wrap 63 -> 0 (RR_EN = 1), or upward from 0 (RR_EN = 0).
  - No combinational path from alloc_ready or free_* to alloc_idx or alloc_valid.
- Grant: alloc_valid & alloc_ready at an edge.
  - Sets busy[alloc_idx].
  - rr_ptr <= alloc_idx + 1, mod 64, so 63 wraps to 0.
  - Zero-cycle offer latency; busy_vec reflects the grant one cycle later.
- Release: free_valid at an edge.
  - If busy[free_idx] = 1: clear it.
  - Otherwise: no state change except err_dbl_free <= 1.
  - A freed entry becomes offerable the cycle after the edge; a free never bypasses into the same-cycle offer.
- Grant and release in the same cycle (indices necessarily differ, because the grant target is free):
  - Both apply.
  - free_cnt is unchanged.
- free_cnt update: next = free_cnt − grant + valid_free, where valid_free excludes double frees. The count never leaves 0..64.
- Flush at an edge:
  - busy_vec <= 0, free_cnt <= 64, rr_ptr <= 0.
  - Same-cycle grant and free are ignored, including the double-free check.
  - err_dbl_free is retained; only resetn clears it.
- Full: alloc_valid = 0, and alloc_ready is ignored.
- Invariant: free_cnt == 64 − popcount(busy_vec) on every cycle. Checked by an assertion in the bench.
- State: the bitmap, the counter, the pointer and the error flag. No FSM beyond these registers.

Test Plan:
- Reset then 64 back-to-back grants (alloc_ready = 1, RR_EN = 1):
  - alloc_idx goes 0,1,...,63.
  - After the last grant: full = 1, alloc_valid = 0, free_cnt = 0, busy_vec = all ones.
- From full, free 10 then free 5 on consecutive cycles:
  - free_cnt = 2.
  - Next offer is 5: rr_ptr = 0 after the wrap, so the upward search hits 5 first.
  - With RR_EN = 0 the next offer is also 5.
- Wrap check: grant 0..40, free 3, then grant once:
  - RR_EN = 1: offered index is 41, not 3.
  - RR_EN = 0: offered index is 3.
- Simultaneous grant of 7 and free of 2 in one cycle:
  - busy[7] = 1, busy[2] = 0, free_cnt unchanged.
  - Index 2 is not offered during the same cycle.
- Free of the non-busy index 20:
  - busy_vec and free_cnt unchanged; err_dbl_free = 1 from the next cycle.
  - The flag survives a flush and clears only on resetn = 0.
- Flush asserted with alloc_ready = 1 and free_valid = 1:
  - alloc_valid = 0 that cycle; no grant is recorded.
  - Next cycle: busy_vec = 0, free_cnt = 64, alloc_idx = 0.
  - Repeat with resetn = 0 in place of flush: identical result.

Source files
------------

// File: rtl/entry_alloc_64_if.sv
// Allocation/release handshake bundle for entry_alloc_64.
// master = requester side, slave = allocator side.
interface entry_alloc_64_if;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [5:0] alloc_idx;
  logic       free_valid;
  logic [5:0] free_idx;

  modport master (
    input  alloc_valid,
    input  alloc_idx,
    output alloc_ready,
    output free_valid,
    output free_idx
  );

  modport slave (
    output alloc_valid,
    output alloc_idx,
    input  alloc_ready,
    input  free_valid,
    input  free_idx
  );
endinterface

// File: rtl/entry_alloc_64.sv
// 64-entry index allocator: busy bitmap, rotating-priority free search,
// valid/ready grant handshake, index release and sticky double-free flag.
module entry_alloc_64 #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  entry_alloc_64_if.slave  alloc,
  output logic [63:0]      busy_vec,
  output logic [CNT_W-1:0] free_cnt,
  output logic             full,
  output logic             empty,
  output logic             err_dbl_free
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(64);

  logic [63:0]      busy_reg, busy_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       rr_ptr_reg, rr_ptr_next;
  logic             err_reg, err_next;

  logic [5:0]   search_base;
  logic [127:0] free_dbl;
  logic [63:0]  free_rot;
  logic [5:0]   first_off;
  logic [5:0]   offer_idx;
  logic         offer_valid;
  logic         grant;
  logic [63:0]  set_mask;
  logic [63:0]  free_dec;
  logic [63:0]  clr_mask;
  logic         valid_free;
  logic         dbl_free;

  assign search_base = RR_EN ? rr_ptr_reg : 6'd0;

  // Rotate the free map so the search base sits at bit 0; the lowest set
  // bit of the rotated map is then the distance from the base.
  always_comb begin
    free_dbl = {~busy_reg, ~busy_reg};
    free_rot = free_dbl[search_base +: 64];
  end

  always_comb begin
    first_off = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (free_rot[i]) begin
        first_off = 6'(i);
      end
    end
  end

  assign offer_idx   = search_base + first_off;
  assign offer_valid = (cnt_reg != '0) && !flush;
  assign grant       = offer_valid && alloc.alloc_ready;

  assign alloc.alloc_valid = offer_valid;
  assign alloc.alloc_idx   = offer_idx;

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_decode
      assign set_mask[gi] = grant && (offer_idx == 6'(gi));
      assign free_dec[gi] = alloc.free_valid && (alloc.free_idx == 6'(gi));
    end
  endgenerate

  // Only a release of a currently busy entry counts; anything else is a double free.
  assign clr_mask   = free_dec & busy_reg;
  assign valid_free = |clr_mask;
  assign dbl_free   = alloc.free_valid && !valid_free;

  always_comb begin
    busy_next   = busy_reg;
    cnt_next    = cnt_reg;
    rr_ptr_next = rr_ptr_reg;
    err_next    = err_reg;
    if (flush) begin
      busy_next   = '0;
      cnt_next    = CNT_FULL;
      rr_ptr_next = 6'd0;
    end else begin
      busy_next = (busy_reg | set_mask) & ~clr_mask;
      cnt_next  = cnt_reg - CNT_W'(grant) + CNT_W'(valid_free);
      if (grant) begin
        rr_ptr_next = offer_idx + 6'd1;
      end
      if (dbl_free) begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_reg   <= '0;
      cnt_reg    <= CNT_FULL;
      rr_ptr_reg <= 6'd0;
      err_reg    <= 1'b0;
    end else begin
      busy_reg   <= busy_next;
      cnt_reg    <= cnt_next;
      rr_ptr_reg <= rr_ptr_next;
      err_reg    <= err_next;
    end
  end

  assign busy_vec     = busy_reg;
  assign free_cnt     = cnt_reg;
  assign full         = (cnt_reg == '0);
  assign empty        = (cnt_reg == CNT_FULL);
  assign err_dbl_free = err_reg;

endmodule

// File: tb/tb_entry_alloc_64.sv
// Bench for entry_alloc_64: round-robin and fixed-priority instances driven in
// lockstep and compared against a bitmap/pointer reference model.
module tb_entry_alloc_64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       flush;
  logic       ready;
  logic       fv;
  logic [5:0] fi;

  int vectors    = 0;
  int miscompares = 0;
  bit inv_on     = 1'b0;

  entry_alloc_64_if bus_rr();
  entry_alloc_64_if bus_fp();

  assign bus_rr.alloc_ready = ready;
  assign bus_rr.free_valid  = fv;
  assign bus_rr.free_idx    = fi;
  assign bus_fp.alloc_ready = ready;
  assign bus_fp.free_valid  = fv;
  assign bus_fp.free_idx    = fi;

  logic [63:0] busy_rr, busy_fp;
  logic [6:0]  cnt_rr, cnt_fp;
  logic        full_rr, full_fp, empty_rr, empty_fp, err_rr, err_fp;

  entry_alloc_64 #(.RR_EN(1'b1), .CNT_W(7)) dut_rr (
    .clk(clk), .resetn(resetn), .flush(flush), .alloc(bus_rr),
    .busy_vec(busy_rr), .free_cnt(cnt_rr), .full(full_rr), .empty(empty_rr),
    .err_dbl_free(err_rr)
  );

  entry_alloc_64 #(.RR_EN(1'b0), .CNT_W(7)) dut_fp (
    .clk(clk), .resetn(resetn), .flush(flush), .alloc(bus_fp),
    .busy_vec(busy_fp), .free_cnt(cnt_fp), .full(full_fp), .empty(empty_fp),
    .err_dbl_free(err_fp)
  );

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic [6:0]  offer_o[2];
  logic [73:0] state_o[2];
  assign offer_o[0] = {bus_rr.alloc_valid, bus_rr.alloc_valid ? bus_rr.alloc_idx : 6'd0};
  assign offer_o[1] = {bus_fp.alloc_valid, bus_fp.alloc_valid ? bus_fp.alloc_idx : 6'd0};
  assign state_o[0] = {busy_rr, cnt_rr, full_rr, empty_rr, err_rr};
  assign state_o[1] = {busy_fp, cnt_fp, full_fp, empty_fp, err_fp};

  // Reference model
  bit [63:0] m_busy[2];
  int        m_ptr[2];
  bit        m_err[2];

  function automatic int m_cnt(int k);
    return 64 - $countones(m_busy[k]);
  endfunction

  function automatic int m_pick(int k);
    int start = (k == 0) ? m_ptr[k] : 0;
    for (int n = 0; n < 64; n++) begin
      if (!m_busy[k][(start + n) % 64]) return (start + n) % 64;
    end
    return 0;
  endfunction

  function automatic logic [6:0] exp_offer(int k);
    if (m_cnt(k) == 0 || flush) return 7'd0;
    return {1'b1, 6'(m_pick(k))};
  endfunction

  function automatic logic [73:0] exp_state(int k);
    int c = m_cnt(k);
    return {m_busy[k], 7'(c), c == 0, c == 64, m_err[k]};
  endfunction

  task automatic set_in(input logic rn, input logic fl, input logic rd,
                        input logic v, input logic [5:0] i);
    resetn = rn; flush = fl; ready = rd; fv = v; fi = i;
  endtask

  task automatic edge_step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_busy[k] = '0; m_ptr[k] = 0; m_err[k] = 1'b0;
      end else if (flush) begin
        m_busy[k] = '0; m_ptr[k] = 0;
      end else begin
        bit g  = (m_cnt(k) != 0) && ready;
        int gi = m_pick(k);
        if (fv) begin
          if (m_busy[k][fi]) m_busy[k][fi] = 1'b0;
          else               m_err[k] = 1'b1;
        end
        if (g) begin
          m_busy[k][gi] = 1'b1;
          m_ptr[k] = (gi + 1) % 64;
        end
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      for (int k = 0; k < 2; k++) begin
        vectors++;
        assert (state_o[k][9:3] == 7'(64 - $countones(state_o[k][73:10]))) else begin
          miscompares++;
          $display("FAIL invariant dut%0d: free_cnt %0d busy popcount %0d",
                   k, state_o[k][9:3], $countones(state_o[k][73:10]));
        end
      end
    end
  end

  task automatic test_reset();
    set_in(0, 0, 1, 1, 6'd9);
    edge_step();
    edge_step();
    set_in(1, 0, 0, 0, 6'd0);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== {64'd0, 7'd64, 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got %h want %h", k, state_o[k],
                 {64'd0, 7'd64, 1'b0, 1'b1, 1'b0});
      end
      vectors++;
      if (offer_o[k] !== 7'b1_000000) begin
        miscompares++;
        $display("FAIL reset_offer dut%0d: got %h want %h", k, offer_o[k], 7'b1_000000);
      end
    end
    inv_on = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) begin
      set_in(1, 0, 1, 0, 6'd0);
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (offer_o[k] !== {1'b1, 6'(i)}) begin
          miscompares++;
          $display("FAIL b2b_offer dut%0d step %0d: got %h want %h", k, i, offer_o[k], {1'b1, 6'(i)});
        end
      end
      edge_step();
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== {64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 1'b1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_full_state dut%0d: got %h want %h", k, state_o[k],
                 {64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 1'b1, 1'b0, 1'b0});
      end
      vectors++;
      if (offer_o[k] !== 7'd0) begin
        miscompares++;
        $display("FAIL b2b_full_valid dut%0d: got %h want %h", k, offer_o[k], 7'd0);
      end
    end
    edge_step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== exp_state(k)) begin
        miscompares++;
        $display("FAIL full_ignores_ready dut%0d: got %h want %h", k, state_o[k], exp_state(k));
      end
    end
  endtask

  task automatic test_free_from_full();
    set_in(1, 0, 0, 1, 6'd10);
    edge_step();
    set_in(1, 0, 0, 1, 6'd5);
    edge_step();
    set_in(1, 0, 0, 0, 6'd0);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== exp_state(k) || state_o[k][9:3] !== 7'd2) begin
        miscompares++;
        $display("FAIL refill_state dut%0d: got %h want %h", k, state_o[k], exp_state(k));
      end
      vectors++;
      if (offer_o[k] !== {1'b1, 6'd5}) begin
        miscompares++;
        $display("FAIL refill_offer dut%0d: got %h want %h", k, offer_o[k], {1'b1, 6'd5});
      end
    end
  endtask

  task automatic test_wrap();
    logic [5:0] want[2];
    want[0] = 6'd41;
    want[1] = 6'd3;
    set_in(0, 0, 0, 0, 6'd0);
    edge_step();
    for (int i = 0; i <= 40; i++) begin
      set_in(1, 0, 1, 0, 6'd0);
      edge_step();
    end
    set_in(1, 0, 0, 1, 6'd3);
    edge_step();
    set_in(1, 0, 1, 0, 6'd0);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (offer_o[k] !== {1'b1, want[k]} || offer_o[k] !== exp_offer(k)) begin
        miscompares++;
        $display("FAIL wrap_offer dut%0d: got %h want %h", k, offer_o[k], {1'b1, want[k]});
      end
    end
    edge_step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== exp_state(k)) begin
        miscompares++;
        $display("FAIL wrap_state dut%0d: got %h want %h", k, state_o[k], exp_state(k));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] after[2];
    after[0] = 6'd8;
    after[1] = 6'd2;
    set_in(0, 0, 0, 0, 6'd0);
    edge_step();
    for (int i = 0; i < 7; i++) begin
      set_in(1, 0, 1, 0, 6'd0);
      edge_step();
    end
    set_in(1, 0, 1, 1, 6'd2);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (offer_o[k] !== {1'b1, 6'd7}) begin
        miscompares++;
        $display("FAIL simul_offer dut%0d: got %h want %h", k, offer_o[k], {1'b1, 6'd7});
      end
    end
    edge_step();
    set_in(1, 0, 0, 0, 6'd0);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({state_o[k][17], state_o[k][12], state_o[k][9:3]} !== {1'b1, 1'b0, 7'd57}
          || state_o[k] !== exp_state(k)) begin
        miscompares++;
        $display("FAIL simul_state dut%0d: got %h want %h", k, state_o[k], exp_state(k));
      end
      vectors++;
      if (offer_o[k] !== {1'b1, after[k]}) begin
        miscompares++;
        $display("FAIL simul_next_offer dut%0d: got %h want %h", k, offer_o[k], {1'b1, after[k]});
      end
    end
  endtask

  task automatic test_dbl_free();
    set_in(1, 0, 0, 1, 6'd20);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k][0] !== 1'b0) begin
        miscompares++;
        $display("FAIL dbl_early_flag dut%0d: got %b want 0", k, state_o[k][0]);
      end
    end
    edge_step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== exp_state(k) || state_o[k][0] !== 1'b1 || state_o[k][9:3] !== 7'd57) begin
        miscompares++;
        $display("FAIL dbl_state dut%0d: got %h want %h", k, state_o[k], exp_state(k));
      end
    end
    set_in(1, 1, 0, 0, 6'd0);
    edge_step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== {64'd0, 7'd64, 1'b0, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL dbl_after_flush dut%0d: got %h want %h", k, state_o[k],
                 {64'd0, 7'd64, 1'b0, 1'b1, 1'b1});
      end
    end
    set_in(0, 0, 0, 0, 6'd0);
    edge_step();
    set_in(1, 0, 0, 0, 6'd0);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k][0] !== 1'b0) begin
        miscompares++;
        $display("FAIL dbl_after_reset dut%0d: got %b want 0", k, state_o[k][0]);
      end
    end
  endtask

  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        set_in(1, 0, 1, 0, 6'd0);
        edge_step();
      end
      if (pass == 0) set_in(1, 1, 1, 1, 6'd50);
      else           set_in(0, 0, 1, 1, 6'd50);
      #1;
      if (pass == 0) begin
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if (offer_o[k] !== 7'd0) begin
            miscompares++;
            $display("FAIL flush_valid dut%0d: got %h want %h", k, offer_o[k], 7'd0);
          end
        end
      end
      edge_step();
      set_in(1, 0, 0, 0, 6'd0);
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (state_o[k] !== {64'd0, 7'd64, 1'b0, 1'b1, 1'b0} || state_o[k] !== exp_state(k)) begin
          miscompares++;
          $display("FAIL flush_state pass%0d dut%0d: got %h want %h", pass, k, state_o[k], exp_state(k));
        end
        vectors++;
        if (offer_o[k] !== 7'b1_000000) begin
          miscompares++;
          $display("FAIL flush_offer pass%0d dut%0d: got %h want %h", pass, k, offer_o[k], 7'b1_000000);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      logic rn, fl, rd, v;
      logic [5:0] idx;
      rn  = ($urandom_range(99) != 0);
      fl  = ($urandom_range(31) == 0);
      rd  = ($urandom_range(2) != 0);
      v   = ($urandom_range(2) == 0);
      idx = 6'($urandom_range(63));
      if (!m_busy[0][idx] && $urandom_range(3) != 0) begin
        for (int s = 1; s < 64; s++) begin
          if (m_busy[0][(int'(idx) + s) % 64]) begin
            idx = 6'((int'(idx) + s) % 64);
            break;
          end
        end
      end
      set_in(rn, fl, rd, v, idx);
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (offer_o[k] !== exp_offer(k)) begin
          miscompares++;
          $display("FAIL rand_offer dut%0d cyc %0d: got %h want %h", k, n, offer_o[k], exp_offer(k));
        end
      end
      edge_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (state_o[k] !== exp_state(k)) begin
          miscompares++;
          $display("FAIL rand_state dut%0d cyc %0d: got %h want %h", k, n, state_o[k], exp_state(k));
        end
      end
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 6'd0);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_free_from_full();
    test_wrap();
    test_simultaneous();
    test_dbl_free();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
